thirty_two_bit_shift_add_multiplier: RTL and testbench

//   Unsigned 32x32->64 sequential multiplier for the ALU datapath; one multiplier bit per clock.

---
 rtl/thirty_two_bit_shift_add_multiplier.sv | 129 ++++++++++++
 tb/tb_thirty_two_bit_shift_add_multiplier.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/thirty_two_bit_shift_add_multiplier.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH sequential shift-add multiplier, one multiplier bit per clock.
// Holds its own ripple adder instance; the adder's carry_out becomes the accumulator MSB each step.

module thirty_two_bit_full_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
endmodule

module thirty_two_bit_shift_add_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic [WIDTH-1:0]     step_s;
    logic                 step_c;
    logic [2*WIDTH-1:0]   step_acc;
    logic                 accept;
    logic                 last_step;

    thirty_two_bit_full_adder #(.WIDTH(WIDTH)) u_adder (
        .a         (acc_hi_q),
        .b         (mcand_q),
        .carry_in  (1'b0),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // Add the multiplicand only when the current multiplier LSB is set, then shift the 65-bit value right.
    always_comb begin
        if (acc_lo_q[0]) begin
            step_c = add_cout;
            step_s = add_sum;
        end else begin
            step_c = 1'b0;
            step_s = acc_hi_q;
        end
        step_acc = {step_c, step_s, acc_lo_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (accept) begin
            mcand_d  = a;
            acc_hi_d = '0;
            acc_lo_d = b;
            cnt_d    = '0;
        end else if (state_q == RUN) begin
            {acc_hi_d, acc_lo_d} = step_acc;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
                product_d = step_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
endmodule

// File: tb/tb_thirty_two_bit_shift_add_multiplier.sv
// Scoreboard bench for the sequential multiplier: driver queues a*b, a monitor checks each done pulse.

module tb_thirty_two_bit_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [63:0] product;

    logic [63:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    thirty_two_bit_shift_add_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("busy_done_exclusive", {63'b0, busy}, 64'd0);
            if (exp_q.size() == 0) begin
                check("spurious_done", {63'b0, done}, 64'd0);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        exp_q.push_back(64'(x) * 64'(y));
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge; counts edges (accept edge = 1) and busy samples.
    task automatic wait_done(input bit noise, output int edges, output int bcnt);
        edges = 1;
        bcnt  = 0;
        while (!done && edges < 100) begin
            if (busy) bcnt++;
            if (noise && edges < 30 && (edges % 5 == 2)) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit noise, input bit chk_lat);
        int edges, bcnt;
        issue(x, y);
        wait_done(noise, edges, bcnt);
        if (chk_lat) begin
            check("latency_edges", 64'(edges), 64'd33);
            check("busy_cycles", 64'(bcnt), 64'd32);
        end else if (edges >= 100) begin
            check("done_timeout", 64'(edges), 64'd33);
        end
    endtask

    initial begin
        int edges, bcnt;
        logic [31:0] x, y;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd3, 32'd5, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op(32'h1234_5678, 32'd0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("product_held", product, 64'd0);

        // Start held high through DONE re-enters RUN with the new operands.
        issue(32'hDEAD_BEEF, 32'h0000_1001);
        a = 32'd7;
        b = 32'd6;
        exp_q.push_back(64'd42);
        edges = 1;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("held_first_latency", 64'(edges), 64'd33);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, edges, bcnt);
        check("held_second_latency", 64'(edges), 64'd33);

        // Reset mid-RUN discards the operation.
        issue(32'd9, 32'd9);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy_before_rst", {63'b0, busy}, 64'd1);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun_rst_busy", {63'b0, busy}, 64'd0);
        check("midrun_rst_done", {63'b0, done}, 64'd0);
        check("midrun_rst_product", product, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("no_done_after_rst", {63'b0, done}, 64'd0);
        check("product_after_rst", product, 64'd0);
        run_op(32'd9, 32'd9, 1'b0, 1'b1);

        // Randomized operations, including corner operands.
        for (int i = 0; i < 24; i++) begin
            case (i % 6)
                0: begin x = 32'h8000_0000; y = $urandom; end
                1: begin x = $urandom; y = 32'h0000_0001; end
                default: begin x = $urandom; y = $urandom; end
            endcase
            run_op(x, y, (i % 4) == 3, (i % 3) == 0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
